renode_axi_lite_target: RTL

Synthesizable AXI4-Lite subordinate with a parameterized register bank and programmable response latency. It is the responder end of the co-simulation bus controller: read/write requests from Renode are driven onto AXI4-Lite and answered here, so the bench can exercise the controller path, including timeout and error handling, against real RTL. It also serves as a default memory-mapped peripheral in Verilated designs.

---
 rtl/renode_axi_lite_target.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/renode_axi_lite_target.sv
// renode_axi_lite_target: AXI4-Lite subordinate with a register bank and programmable response latency.
// Ports:
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   awvalid/awready/awaddr/awprot   write-address channel (awprot ignored)
//   wvalid/wready/wdata/wstrb       write-data channel, byte enables in wstrb
//   bvalid/bready/bresp             write-response channel (OKAY or SLVERR)
//   arvalid/arready/araddr/arprot   read-address channel (arprot ignored)
//   rvalid/rready/rdata/rresp       read-data channel (OKAY or SLVERR, rdata 0 on error)
module renode_axi_lite_target #(
    parameter int AddressWidth    = 32,
    parameter int DataWidth       = 32,
    parameter int RegisterCount   = 16,
    parameter int BaseAddress     = 0,
    parameter int ResponseLatency = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [AddressWidth-1:0] awaddr,
    input  logic [2:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DataWidth-1:0]    wdata,
    input  logic [DataWidth/8-1:0]  wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [AddressWidth-1:0] araddr,
    input  logic [2:0]              arprot,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DataWidth-1:0]    rdata,
    output logic [1:0]              rresp
);
    localparam int Bytes = DataWidth / 8;
    localparam int Shift = $clog2(Bytes);
    localparam int IdxW = RegisterCount > 1 ? $clog2(RegisterCount) : 1;
    localparam logic [AddressWidth-1:0] Base = AddressWidth'(BaseAddress);
    localparam logic [AddressWidth-1:0] Count = AddressWidth'(RegisterCount);
    localparam logic [7:0] Latency = 8'(ResponseLatency);

    if (DataWidth != 32 && DataWidth != 64) begin : g_bad_width
        $error("DataWidth must be 32 or 64");
    end
    if (RegisterCount < 1) begin : g_bad_count
        $error("RegisterCount must be at least 1");
    end
    if (BaseAddress % Bytes != 0) begin : g_bad_base
        $error("BaseAddress must be aligned to DataWidth/8");
    end
    if (ResponseLatency < 0 || ResponseLatency > 255) begin : g_bad_latency
        $error("ResponseLatency must be in 0..255");
    end

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    function automatic logic in_range(input logic [AddressWidth-1:0] a);
        return a >= Base && ((a - Base) >> Shift) < Count;
    endfunction

    function automatic logic [IdxW-1:0] index_of(input logic [AddressWidth-1:0] a);
        return IdxW'((a - Base) >> Shift);
    endfunction

    logic [DataWidth-1:0]    regs [RegisterCount];
    w_state_t                w_state;
    r_state_t                r_state;
    logic                    aw_held, w_held;
    logic [AddressWidth-1:0] waddr, raddr;
    logic [DataWidth-1:0]    wdata_q;
    logic [Bytes-1:0]        wstrb_q;
    logic [7:0]              w_cnt, r_cnt;
    logic                    aw_got, w_got, w_ok, r_ok;
    logic [IdxW-1:0]         w_idx, r_idx;
    logic                    unused_prot;

    // An address/data beat counts as held if captured earlier or handshaking this cycle.
    assign aw_got = aw_held || (awvalid && awready);
    assign w_got = w_held || (wvalid && wready);
    assign w_ok = in_range(waddr);
    assign r_ok = in_range(raddr);
    assign w_idx = index_of(waddr);
    assign r_idx = index_of(raddr);
    assign unused_prot = ^{awprot, arprot};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            awready <= 1'b0;
            wready <= 1'b0;
            bvalid <= 1'b0;
            bresp <= 2'b00;
            w_cnt <= 8'd0;
            for (int i = 0; i < RegisterCount; i++) regs[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) waddr <= awaddr;
                    if (wvalid && wready) begin
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    aw_held <= aw_got;
                    w_held <= w_got;
                    awready <= !aw_got && !w_got || !aw_got;
                    wready <= !w_got;
                    if (aw_got && w_got) begin
                        w_state <= W_WAIT;
                        w_cnt <= Latency;
                        awready <= 1'b0;
                        wready <= 1'b0;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 8'd0) begin
                        if (w_ok)
                            for (int b = 0; b < Bytes; b++)
                                if (wstrb_q[b]) regs[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        bvalid <= 1'b1;
                        bresp <= w_ok ? 2'b00 : 2'b10;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        aw_held <= 1'b0;
                        w_held <= 1'b0;
                        awready <= 1'b1;
                        wready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs before any same-edge write commit lands, so a collision returns the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rresp <= 2'b00;
            rdata <= '0;
            r_cnt <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        raddr <= araddr;
                        arready <= 1'b0;
                        r_cnt <= Latency;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        rdata <= r_ok ? regs[r_idx] : '0;
                        rresp <= r_ok ? 2'b00 : 2'b10;
                        rvalid <= 1'b1;
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
